elastic_pipe_line: RTL and testbench

//  Parameterised DEPTH-stage register pipeline with valid/ready flow control on both sides.

---
 rtl/elastic_pipe_line.sv | 60 ++++++
 tb/tb_elastic_pipe_line.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe_line.sv
// elastic_pipe_line: DEPTH-stage valid/ready register pipeline with bubble collapse,
// registered occupancy and a saturating stall-cycle counter.
module elastic_pipe_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [15:0]      stall_cnt
);
  logic [DEPTH-1:0]            v_q, v_d, adv;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic [15:0]                 stall_q, stall_d;
  logic                        in_xfer, out_xfer;
  // A stage can move when any stage from it to the output is empty, or the output drains.
  for (genvar i = 0; i < DEPTH; i++) begin : g_adv
    assign adv[i] = out_ready || !(&v_q[DEPTH-1:i]);
  end
  assign in_ready  = adv[0];
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;
  assign in_xfer   = in_valid && adv[0];
  assign out_xfer  = v_q[DEPTH-1] && out_ready;
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    v_d[0] = adv[0] ? in_valid : v_q[0];
    d_d[0] = in_xfer ? in_data : d_q[0];
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k] = adv[k] ? v_q[k-1] : v_q[k];
      d_d[k] = (adv[k] && v_q[k-1]) ? d_q[k-1] : d_q[k];
    end
    occ_d   = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    stall_d = stall_q + 16'(out_valid && !out_ready && stall_q != 16'hFFFF);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      d_q     <= '0;
      occ_q   <= '0;
      stall_q <= '0;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      occ_q   <= occ_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_elastic_pipe_line.sv
// tb_elastic_pipe_line: directed scenarios plus random traffic against a position-based
// queue model of the pipeline.
module tb_elastic_pipe_line;
  localparam int W = 8, D = 4, OW = $clog2(D + 1);
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [W-1:0] in_data = '0, out_data;
  logic [OW-1:0] occupancy;
  logic [15:0] stall_cnt;
  int total = 0, bad = 0;
  logic [W-1:0] mq_d[$];
  int mq_p[$];
  logic [15:0] mstall = '0;

  always #5 clk = ~clk;

  elastic_pipe_line #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  // Model: ordered words with a slot position; each word moves one slot toward the output
  // unless the word ahead of it still blocks the next slot.
  always @(posedge clk or negedge rst_n) begin
    int n, lim, np;
    bit ir, at_out;
    if (!rst_n) begin
      mq_d.delete();
      mq_p.delete();
      mstall = '0;
    end else begin
      n = mq_p.size();
      ir = (n < D) || out_ready;
      at_out = 0;
      if (n > 0) at_out = (mq_p[0] == D - 1);
      if (at_out && !out_ready && mstall != 16'hFFFF) mstall = mstall + 16'd1;
      lim = D;
      if (at_out && out_ready) begin
        void'(mq_d.pop_front());
        void'(mq_p.pop_front());
      end
      for (int k = 0; k < mq_p.size(); k++) begin
        np = (mq_p[k] + 1 < lim - 1) ? mq_p[k] + 1 : lim - 1;
        mq_p[k] = np;
        lim = np;
      end
      if (in_valid && ir) begin
        mq_d.push_back(in_data);
        mq_p.push_back(0);
      end
    end
  end

  function automatic logic m_ov();
    if (mq_p.size() == 0) return 1'b0;
    return mq_p[0] == D - 1;
  endfunction

  function automatic logic [W-1:0] m_od();
    if (mq_d.size() == 0) return '0;
    return mq_d[0];
  endfunction

  function automatic logic m_ir();
    return (mq_p.size() < D) || out_ready;
  endfunction

  function automatic logic [OW-1:0] m_occ();
    return OW'(mq_p.size());
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic test_stream();
    int first = -1;
    logic [W-1:0] got[$];
    logic [W-1:0] exp_w;
    out_ready = 1;
    for (int e = 0; e < 12; e++) begin
      in_valid = (e < 4);
      in_data = 8'(8'h11 + e);
      #1;
      if (out_valid && first < 0) first = e;
      if (out_valid) got.push_back(out_data);
      total++; if (out_valid !== m_ov()) begin bad++; $display("FAIL stream_valid e=%0d got=%0h exp=%0h", e, out_valid, m_ov()); end
      tick();
    end
    in_valid = 0;
    total++; if (first !== 4) begin bad++; $display("FAIL stream_latency got=%0d exp=4", first); end
    total++; if (got.size() !== 4) begin bad++; $display("FAIL stream_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      exp_w = 8'(8'h11 + i);
      total++; if (got[i] !== exp_w) begin bad++; $display("FAIL stream_order i=%0d got=%0h exp=%0h", i, got[i], exp_w); end
    end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_fill();
    int acc = 0;
    out_ready = 0;
    for (int e = 0; e < 8; e++) begin
      in_valid = 1;
      in_data = 8'(8'hA0 + acc);
      #1;
      total++; if (in_ready !== m_ir()) begin bad++; $display("FAIL fill_in_ready e=%0d got=%0h exp=%0h", e, in_ready, m_ir()); end
      total++; if (stall_cnt !== mstall) begin bad++; $display("FAIL fill_stall e=%0d got=%0d exp=%0d", e, stall_cnt, mstall); end
      if (in_ready) acc++;
      tick();
    end
    in_valid = 0;
    #1;
    total++; if (acc !== 4) begin bad++; $display("FAIL fill_accepted got=%0d exp=4", acc); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%0h exp=0", in_ready); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_occupancy got=%0d exp=4", occupancy); end
    total++; if (out_data !== 8'hA0) begin bad++; $display("FAIL fill_hold got=%0h exp=a0", out_data); end
    total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL fill_stall_total got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_drain();
    logic [W-1:0] exp_w;
    in_valid = 0;
    out_ready = 1;
    for (int e = 0; e < 4; e++) begin
      #1;
      exp_w = 8'(8'hA0 + e);
      total++; if (occupancy !== OW'(4 - e)) begin bad++; $display("FAIL drain_occ e=%0d got=%0d exp=%0d", e, occupancy, 4 - e); end
      total++; if (out_valid !== 1'b1 || out_data !== exp_w) begin bad++; $display("FAIL drain_data e=%0d got=%0h/%0h exp=1/%0h", e, out_valid, out_data, exp_w); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready e=%0d got=%0h exp=1", e, in_ready); end
      tick();
    end
    #1;
    total++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0d/%0h exp=0/0", occupancy, out_valid); end
  endtask

  task automatic test_full_both();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data = 8'(8'hB0 + i);
      tick();
    end
    in_data = 8'hB4;
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL both_ready got=%0h exp=1", in_ready); end
    total++; if (occupancy !== 3'd4 || out_data !== 8'hB0) begin bad++; $display("FAIL both_pre got=%0d/%0h exp=4/b0", occupancy, out_data); end
    tick();
    in_valid = 0;
    #1;
    total++; if (occupancy !== 3'd4 || out_data !== 8'hB1) begin bad++; $display("FAIL both_post got=%0d/%0h exp=4/b1", occupancy, out_data); end
    for (int e = 0; e < 5; e++) begin
      total++; if (out_valid !== m_ov() || (m_ov() && out_data !== m_od())) begin bad++; $display("FAIL both_drain e=%0d got=%0h/%0h exp=%0h/%0h", e, out_valid, out_data, m_ov(), m_od()); end
      tick();
    end
  endtask

  task automatic test_bubble();
    logic [7:0] pat;
    pat = 8'b0000_1001;
    out_ready = 0;
    for (int e = 0; e < 8; e++) begin
      in_valid = pat[e];
      in_data = (e == 0) ? 8'h55 : 8'h66;
      tick();
    end
    in_valid = 0;
    #1;
    total++; if (dut.v_q !== 4'b1100) begin bad++; $display("FAIL bubble_valids got=%b exp=1100", dut.v_q); end
    total++; if (dut.d_q[3] !== 8'h55 || dut.d_q[2] !== 8'h66) begin bad++; $display("FAIL bubble_stages got=%0h/%0h exp=55/66", dut.d_q[3], dut.d_q[2]); end
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL bubble_occ got=%0d exp=2", occupancy); end
    out_ready = 1;
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin bad++; $display("FAIL bubble_out0 got=%0h/%0h exp=1/55", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin bad++; $display("FAIL bubble_out1 got=%0h/%0h exp=1/66", out_valid, out_data); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bubble_out2 got=%0h exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_data = 8'(8'hC0 + i);
      tick();
    end
    in_valid = 0;
    tick();
    tick();
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL mid_occ got=%0d exp=3", occupancy); end
    total++; if (stall_cnt !== mstall || mstall == 16'd0) begin bad++; $display("FAIL mid_stall got=%0d exp=%0d", stall_cnt, mstall); end
    #2 rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL mid_out got=%0h/%0h exp=0/0", out_valid, out_data); end
    total++; if (occupancy !== 3'd0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL mid_stats got=%0d/%0d exp=0/0", occupancy, stall_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%0h exp=1", in_ready); end
    #1 rst_n = 1;
    out_ready = 1;
    for (int e = 0; e < 6; e++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_ghost e=%0d got=%0h exp=0", e, out_valid); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = (i < 200) ? 1'($urandom % 2) : ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      #1;
      total++; if (in_ready !== m_ir()) begin bad++; $display("FAIL rnd_ready i=%0d got=%0h exp=%0h", i, in_ready, m_ir()); end
      total++; if (out_valid !== m_ov()) begin bad++; $display("FAIL rnd_valid i=%0d got=%0h exp=%0h", i, out_valid, m_ov()); end
      if (m_ov()) begin
        total++; if (out_data !== m_od()) begin bad++; $display("FAIL rnd_data i=%0d got=%0h exp=%0h", i, out_data, m_od()); end
      end
      total++; if (occupancy !== m_occ()) begin bad++; $display("FAIL rnd_occ i=%0d got=%0d exp=%0d", i, occupancy, m_occ()); end
      total++; if (stall_cnt !== mstall) begin bad++; $display("FAIL rnd_stall i=%0d got=%0d exp=%0d", i, stall_cnt, mstall); end
      tick();
    end
  endtask

  task automatic test_saturation();
    out_ready = 0;
    in_valid = 1;
    in_data = 8'h5A;
    tick();
    in_valid = 0;
    repeat (65540) @(posedge clk);
    #1;
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_value got=%0h exp=ffff", stall_cnt); end
    total++; if (out_valid !== m_ov() || out_data !== m_od()) begin bad++; $display("FAIL sat_hold got=%0h/%0h exp=%0h/%0h", out_valid, out_data, m_ov(), m_od()); end
    tick();
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_nowrap got=%0h exp=ffff", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_drain();
    test_full_both();
    test_bubble();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
